alu_acc_ctrl: RTL

//   Accumulator controller directly upstream/downstream of the 32-bit alu.
//   - Accepts one command per valid/ready handshake.
//   - For EXEC: drives alu A = accumulator, B = sign-extended operand, Op = requested code.
//   - Registers alu Out/Zero back into the accumulator.
//   - Front end for the calculator and the first sequential datapath stage around the alu.

---
 rtl/alu_acc_ctrl_if.sv | 34 +++
 rtl/alu_acc_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/alu_acc_ctrl_if.sv
// ============================================================================
//  Module : alu_acc_ctrl_if
//  Brief  : Command request handshake bundle for the accumulator controller.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_acc_ctrl_if #(
  parameter int OPND_W = 16
) ();
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_cmd;
  logic [3:0]        req_op;
  logic [OPND_W-1:0] req_operand;

  modport master (
    output req_valid,
    output req_cmd,
    output req_op,
    output req_operand,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_cmd,
    input  req_op,
    input  req_operand,
    output req_ready
  );
endinterface

`default_nettype wire

// File: rtl/alu_acc_ctrl.sv
// ============================================================================
//  Module : alu_acc_ctrl
//  Brief  : Accumulator controller wrapped around an external 32-bit alu.
//           Optional macro CALC_UNDO_EN adds a one-deep undo (swap) register.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_acc_ctrl #(
  parameter int DATA_W = 32,
  parameter int OPND_W = 16,
  parameter int CNT_W  = 8
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  alu_acc_ctrl_if.slave          req,
  output logic [DATA_W-1:0]      alu_a_o,
  output logic [DATA_W-1:0]      alu_b_o,
  output logic [3:0]             alu_op_o,
  input  wire logic [DATA_W-1:0] alu_out_i,
  input  wire logic              alu_zero_i,
  output logic [DATA_W-1:0]      acc_o,
  output logic                   zero_flag_o,
  output logic                   done_o,
  output logic                   busy_o,
  output logic [CNT_W-1:0]       op_count_o
);

  localparam logic [1:0]       c_cmd_exec  = 2'b00;
  localparam logic [1:0]       c_cmd_clear = 2'b01;
  localparam logic [1:0]       c_cmd_load  = 2'b10;
  localparam logic [CNT_W-1:0] c_cnt_max   = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                zero_q, zero_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          op_q, op_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
`ifdef CALC_UNDO_EN
  logic [DATA_W-1:0]   prev_q, prev_d;
`endif

  logic [DATA_W-1:0]   w_sext;
  logic                w_ready;

  assign w_sext  = {{(DATA_W-OPND_W){req.req_operand[OPND_W-1]}}, req.req_operand};
  assign w_ready = (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
`ifdef CALC_UNDO_EN
    prev_d  = prev_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req.req_valid) begin
          op_d   = req.req_op;
          opnd_d = w_sext;
          case (req.req_cmd)
            c_cmd_exec: begin
              state_d = S_EXEC;
            end
            c_cmd_clear: begin
              acc_d   = '0;
              zero_d  = 1'b1;
`ifdef CALC_UNDO_EN
              prev_d  = acc_q;
`endif
              state_d = S_DONE;
            end
            c_cmd_load: begin
              acc_d   = w_sext;
              zero_d  = (w_sext == '0);
`ifdef CALC_UNDO_EN
              prev_d  = acc_q;
`endif
              state_d = S_DONE;
            end
            default: begin
              // UNDO: swap with the saved value; a plain no-op when undo is absent
`ifdef CALC_UNDO_EN
              acc_d   = prev_q;
              prev_d  = acc_q;
              zero_d  = (prev_q == '0);
`endif
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_EXEC: begin
        acc_d   = alu_out_i;
        zero_d  = alu_zero_i;
        cnt_d   = (cnt_q == c_cnt_max) ? cnt_q : cnt_q + CNT_W'(1);
`ifdef CALC_UNDO_EN
        prev_d  = acc_q;
`endif
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      zero_q  <= 1'b1;
      cnt_q   <= '0;
      op_q    <= '0;
      opnd_q  <= '0;
`ifdef CALC_UNDO_EN
      prev_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
`ifdef CALC_UNDO_EN
      prev_q  <= prev_d;
`endif
    end
  end

  // alu inputs come straight from registers so they stay stable through EXEC
  assign alu_a_o       = acc_q;
  assign alu_b_o       = opnd_q;
  assign alu_op_o      = op_q;
  assign acc_o         = acc_q;
  assign zero_flag_o   = zero_q;
  assign op_count_o    = cnt_q;
  assign done_o        = (state_q == S_DONE);
  assign req.req_ready = w_ready;
  assign busy_o        = ~w_ready;

endmodule

`default_nettype wire
